// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares a two-entry register file between two requesters.
// Round-robin arbitration over a req/gnt/done handshake, one command per
// three cycles (IDLE -> ACCESS -> DONE).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[1:0], we[1:0]   per-requester request and command type (1 = write)
//   rd_sel, rs_sel      per-requester addresses, slice [i*AW +: AW]
//   wdata               per-requester write data, slice [i*DW +: DW]
//   gnt[1:0]            pulse: command of requester i latched (IDLE cycle)
//   done[1:0]           pulse: command of requester i complete
//   rdata_rd, rdata_rs  register[rd] / register[rs] of last completed read
//   rf_rd, rf_rs        register file addresses (hold latched command)
//   rf_regwrite         register file write enable (ACCESS with write only)
//   rf_wdata            register file write data
//   rf_out1, rf_out0    register file read data (reg[rd], reg[rs])
//
// Build option: define REGFILE_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins a tie; round-robin pointer held at 0).

module regfile_arbiter #(
    parameter int DW = 8,
    parameter int AW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [2*AW-1:0] rd_sel,
    input  logic [2*AW-1:0] rs_sel,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata_rd,
    output logic [DW-1:0]   rdata_rs,
    output logic [AW-1:0]   rf_rd,
    output logic [AW-1:0]   rf_rs,
    output logic            rf_regwrite,
    output logic [DW-1:0]   rf_wdata,
    input  logic [DW-1:0]   rf_out1,
    input  logic [DW-1:0]   rf_out0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            win_q, win_d;
    logic            we_q, we_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   rs_q, rs_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic [DW-1:0]   rdr_q, rdr_d;
    logic [DW-1:0]   rds_q, rds_d;
    logic            win;

    // Winner among current requests; only meaningful when req != 0.
    always_comb begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        win = ~req[0];
`else
        win = (&req) ? rr_q : req[1];
`endif
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        we_d    = we_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        wd_d    = wd_q;
        rdr_d   = rdr_q;
        rds_d   = rds_q;
        gnt     = '0;
        done    = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d = win;
                    we_d  = we[win];
                    rd_d  = win ? rd_sel[2*AW-1:AW] : rd_sel[AW-1:0];
                    rs_d  = win ? rs_sel[2*AW-1:AW] : rs_sel[AW-1:0];
                    wd_d  = win ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                    // Gate with reset so no grant is shown while held in reset.
                    gnt[win] = rst_n;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
                    rr_d = ~win;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdr_d = rf_out1;
                    rds_d = rf_out0;
                end
                state_d = DONE;
            end
            DONE: begin
                done[win_q] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            rs_q    <= '0;
            wd_q    <= '0;
            rdr_q   <= '0;
            rds_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            wd_q    <= wd_d;
            rdr_q   <= rdr_d;
            rds_q   <= rds_d;
        end
    end

    // Decoded from the async-reset state so a reset drops the write at once.
    assign rf_regwrite = (state_q == ACCESS) && we_q;
    assign rf_rd       = rd_q;
    assign rf_rs       = rs_q;
    assign rf_wdata    = wd_q;
    assign rdata_rd    = rdr_q;
    assign rdata_rs    = rds_q;

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Sequences and shares the 8-bit two-entry register file between two requesters (e.g. ALU writeback and load/store unit).
- Accepts one read or write command per requester via req/gnt/done handshake and arbitrates round-robin.
- Drives the register file's rd/rs/regWrite/writeData inputs and captures its two read outputs into registered result buses.
- Register file itself is unchanged and is instantiated alongside this block.

Parameters:
- DW, 8, data width of register file entries.
- AW, 1, register address width (2 entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  per-requester request, bit i = requester i.
- we  input  2  per-requester command type: 1 = write, 0 = read.
- rd_sel  input  2*AW  per-requester rd address, slice [i*AW +: AW].
- rs_sel  input  2*AW  per-requester rs address (reads only).
- wdata  input  2*DW  per-requester write data, slice [i*DW +: DW].
- gnt  output  2  one-cycle pulse: command of requester i latched.
- done  output  2  one-cycle pulse: command of requester i complete.
- rdata_rd  output  DW  register[rd] of last completed read.
- rdata_rs  output  DW  register[rs] of last completed read.
- rf_rd  output  AW  to register file rd.
- rf_rs  output  AW  to register file rs.
- rf_regwrite  output  1  to register file regWrite.
- rf_wdata  output  DW  to register file writeData.
- rf_out1  input  DW  from register file outData1 (= reg[rd]).
- rf_out0  input  DW  from register file outData0 (= reg[rs]).

Behaviour:
- Reset (async, rst_n=0): state IDLE; rr pointer = 0 (requester 0 preferred); gnt, done, rf_regwrite = 0; rf_rd, rf_rs, rf_wdata, rdata_rd, rdata_rs = 0. Reset mid-transaction aborts: rf_regwrite drops immediately, no done issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if req != 0, select winner (if both set, winner = rr pointer; else the single requester). Latch winner's we, rd, rs, wdata into command registers; gnt[winner] = 1 for this cycle; rr pointer <= ~winner; go to ACCESS. Otherwise stay.
- ACCESS (1 cycle): rf_rd/rf_rs/rf_wdata = latched values; rf_regwrite = latched we. At cycle end: if read, rdata_rd <= rf_out1, rdata_rs <= rf_out0. Go to DONE.
- DONE (1 cycle): rf_regwrite = 0; done[winner] = 1; go to IDLE.
- rf_rd/rf_rs/rf_wdata hold latched values outside ACCESS; only rf_regwrite is state-gated. rf_regwrite is high only in ACCESS with we=1.
- Latency: gnt at cycle 0, done at cycle 2. Max throughput one command per 3 cycles.
- Handshake: requester holds req and command fields stable until gnt; may change them after gnt; holds req until done, then may re-raise on the following cycle. Dropping req after gnt does not abort the command.
- rdata_* valid from the done cycle; held until the next completed read. Writes leave rdata_* unchanged.
- Read after write to the same register returns new data (write completes in ACCESS before any later ACCESS).
- Address width: AW=1 covers both entries; no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins a simultaneous request; rr pointer unused and held at 0.
- Undefined: round-robin as described above.

Test Plan:
- Reset: rst_n=0 mid-ACCESS with we=1 -> rf_regwrite=0 asynchronously; all outputs 0; no done; state returns to IDLE.
- Single write then read: req0 write rd=1, wdata=8'hA5 -> gnt[0] cycle 0, rf_regwrite=1 cycle 1, done[0] cycle 2. Then req0 read rd=1, rs=0 -> rdata_rd=8'hA5, rdata_rs=8'h00 at done.
- Simultaneous requests after reset: req=2'b11 held (req0 writes r0=8'h11, req1 writes r1=8'h22) -> gnt[0] first, then gnt[1] 3 cycles later. Read back gives r0=8'h11, r1=8'h22.
- Fairness: req=2'b11 continuously re-raised for 4 commands -> grant order 0,1,0,1. With REGFILE_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
- Read does not disturb: write r0=8'h3C; read by req1 with rd=0, rs=0 -> rdata_rd=rdata_rs=8'h3C; a subsequent write leaves rdata_* at 8'h3C.
- Req drop after grant: req0 deasserted the cycle after gnt[0] -> command still completes and done[0] pulses at cycle 2.
